// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between the CPU bridge master and the SRAM responder.
// Clock and reset stay outside the bundle as plain ports.
interface axi_sram_slave_if #(
  parameter int unsigned ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 responder serving one read or write burst at a time from an internal
// word-addressed memory, with round-robin arbitration between AR and AW.
//
// state   | meaning
// S_IDLE  | waiting for AR/AW, ready granted by priority
// S_RD    | presenting registered read beats
// S_WR    | accepting write beats
// S_WRESP | holding the write response until bready
module axi_sram_slave #(
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ID_W      = 4
) (
  input logic             aclk,
  input logic             areset,
  axi_sram_slave_if.slave bus
);
  localparam int unsigned DEPTH       = 1 << ADDR_BITS;
  localparam logic [1:0]  RESP_OKAY   = 2'd0;
  localparam logic [1:0]  RESP_SLVERR = 2'd2;
  localparam logic        PRIO_READ   = 1'b0;
  localparam logic        PRIO_WRITE  = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_WRESP} state_t;

  function automatic logic in_range(input logic [31:0] a);
    return a[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2];
  endfunction

  function automatic logic [ADDR_BITS-1:0] word_idx(input logic [31:0] a);
    return a[ADDR_BITS+1:2];
  endfunction

  state_t          state_q, state_d;
  logic            prio_q, prio_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            fixed_q, fixed_d;
  logic            err_q, err_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            rlast_q, rlast_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [ID_W-1:0] bid_q, bid_d;

  logic [31:0] mem [DEPTH];
  logic        mem_we;
  logic        ar_rdy, aw_rdy, wr_rdy;
  logic [31:0] next_addr, rd_addr, rd_word;
  logic        beat_err, wr_final;
  logic        unused_bits;

  assign unused_bits = ^{bus.arsize, bus.awsize, bus.wid};

  // Readies are held low while reset is asserted so nothing is accepted then.
  assign ar_rdy = ~areset & (state_q == S_IDLE) & (~bus.awvalid | (prio_q == PRIO_READ));
  assign aw_rdy = ~areset & (state_q == S_IDLE) & (~bus.arvalid | (prio_q == PRIO_WRITE));
  assign wr_rdy = ~areset & (state_q == S_WR);

  assign next_addr = fixed_q ? addr_q : addr_q + 32'd4;
  assign rd_addr   = (state_q == S_IDLE) ? bus.araddr : next_addr;
  assign rd_word   = mem[word_idx(rd_addr)];

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    fixed_d  = fixed_q;
    err_d    = err_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rid_d    = rid_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    mem_we   = 1'b0;
    beat_err = 1'b0;
    wr_final = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.arvalid && ar_rdy) begin
          id_d     = bus.arid;
          addr_d   = bus.araddr;
          len_d    = bus.arlen[3:0];
          fixed_d  = (bus.arburst == 2'd0);
          err_d    = bus.arburst[1] | (|bus.arlen[7:4]);
          cnt_d    = '0;
          beat_err = err_d | ~in_range(bus.araddr);
          rvalid_d = 1'b1;
          rid_d    = bus.arid;
          rlast_d  = (bus.arlen[3:0] == 4'd0);
          rdata_d  = beat_err ? 32'd0 : rd_word;
          rresp_d  = beat_err ? RESP_SLVERR : RESP_OKAY;
          state_d  = S_RD;
        end else if (bus.awvalid && aw_rdy) begin
          id_d    = bus.awid;
          addr_d  = bus.awaddr;
          len_d   = bus.awlen[3:0];
          fixed_d = (bus.awburst == 2'd0);
          err_d   = bus.awburst[1] | (|bus.awlen[7:4]) | ~in_range(bus.awaddr);
          cnt_d   = '0;
          state_d = S_WR;
        end
      end
      S_RD: begin
        if (rvalid_q && bus.rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            prio_d   = PRIO_WRITE;
            state_d  = S_IDLE;
          end else begin
            // Range is rechecked per beat so an INCR burst can run off the end.
            addr_d   = next_addr;
            cnt_d    = cnt_q + 4'd1;
            beat_err = err_q | ~in_range(next_addr);
            rdata_d  = beat_err ? 32'd0 : rd_word;
            rresp_d  = beat_err ? RESP_SLVERR : RESP_OKAY;
            rlast_d  = ((cnt_q + 4'd1) == len_q);
          end
        end
      end
      S_WR: begin
        if (bus.wvalid && wr_rdy) begin
          wr_final = (cnt_q == len_q);
          mem_we   = ~err_q & in_range(addr_q);
          addr_d   = next_addr;
          cnt_d    = cnt_q + 4'd1;
          err_d    = err_q | ~in_range(addr_q) | (bus.wlast ^ wr_final);
          if (wr_final) begin
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = err_d ? RESP_SLVERR : RESP_OKAY;
            state_d  = S_WRESP;
          end
        end
      end
      S_WRESP: begin
        if (bvalid_q && bus.bready) begin
          bvalid_d = 1'b0;
          prio_d   = PRIO_READ;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= S_IDLE;
      prio_q   <= PRIO_READ;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      fixed_q  <= 1'b0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
      rid_q    <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      bid_q    <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      fixed_q  <= fixed_d;
      err_q    <= err_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      rid_q    <= rid_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      bid_q    <= bid_d;
    end
  end

  // Memory contents survive reset on purpose.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) mem[word_idx(addr_q)][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  assign bus.arready = ar_rdy;
  assign bus.awready = aw_rdy;
  assign bus.wready  = wr_rdy;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign bus.rid     = rid_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bid     = bid_q;
endmodule
